// File: rtl/mipi_csi_packet_decoder_nlane.sv
// CSI-2 packet decoder for LANES byte lanes per beat: sync detect, header parse,
// payload forwarding with per-lane byte enables, short-packet and truncation reporting.
module mipi_csi_packet_decoder_nlane #(
  parameter int unsigned LANES     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               data_valid_i,
  input  logic [8*LANES-1:0] data_i,
  output logic               output_valid_o,
  output logic [8*LANES-1:0] data_o,
  output logic [LANES-1:0]   byte_en_o,
  output logic               last_o,
  output logic [2:0]         packet_type_o,
  output logic [1:0]         vc_o,
  output logic [15:0]        word_count_o,
  output logic               short_valid_o,
  output logic [5:0]         short_dt_o,
  output logic               error_o
);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StWaitEnd} state_e;

  state_e             state_q, state_d;
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [31:0]        hdr_q, hdr_d, hdr_next;
  logic [15:0]        rem_q, rem_d;
  logic               ov_q, ov_d;
  logic [8*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]   be_q, be_d;
  logic               last_q, last_d;
  logic [2:0]         type_q, type_d;
  logic [1:0]         vc_q, vc_d;
  logic [15:0]        wc_q, wc_d;
  logic               short_q, short_d;
  logic [5:0]         sdt_q, sdt_d;
  logic               err_q, err_d;
  logic               all_sync;

  function automatic logic [2:0] map_type(input logic [5:0] dt);
    case (dt)
      6'h2A:   return 3'd1;
      6'h2B:   return 3'd2;
      6'h2C:   return 3'd3;
      6'h1E:   return 3'd4;
      6'h24:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    all_sync = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (data_i[8*i +: 8] != SYNC_BYTE) all_sync = 1'b0;
    end
    // Current beat lands at header byte positions hdr_cnt_q .. hdr_cnt_q+LANES-1.
    hdr_next = hdr_q;
    for (int i = 0; i < LANES; i++) begin
      if (int'(hdr_cnt_q) + i < 4) hdr_next[8*(int'(hdr_cnt_q) + i) +: 8] = data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    ov_d      = 1'b0;
    data_d    = data_q;
    be_d      = '0;
    last_d    = 1'b0;
    type_d    = type_q;
    vc_d      = vc_q;
    wc_d      = wc_q;
    short_d   = 1'b0;
    sdt_d     = sdt_q;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (data_valid_i && all_sync) begin
          state_d   = StHeader;
          hdr_cnt_d = 3'd0;
        end
      end
      StHeader: begin
        if (!data_valid_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          hdr_d     = hdr_next;
          hdr_cnt_d = hdr_cnt_q + 3'(LANES);
          if (hdr_cnt_q + 3'(LANES) == 3'd4) begin
            vc_d   = hdr_next[7:6];
            wc_d   = hdr_next[23:8];
            type_d = map_type(hdr_next[5:0]);
            if (hdr_next[5:0] < 6'h10) begin
              short_d = 1'b1;
              sdt_d   = hdr_next[5:0];
              state_d = StWaitEnd;
            end else if (hdr_next[23:8] == 16'd0) begin
              state_d = StWaitEnd;
            end else begin
              rem_d   = hdr_next[23:8];
              state_d = StPayload;
            end
          end
        end
      end
      StPayload: begin
        if (!data_valid_i) begin
          err_d   = 1'b1;
          rem_d   = 16'd0;
          state_d = StIdle;
        end else begin
          data_d = data_i;
          ov_d   = (type_q != 3'd0);
          if (ov_d) begin
            for (int i = 0; i < LANES; i++) be_d[i] = rem_q > 16'(i);
          end
          if (rem_q <= 16'(LANES)) begin
            last_d  = ov_d;
            rem_d   = 16'd0;
            state_d = StWaitEnd;
          end else begin
            rem_d = rem_q - 16'(LANES);
          end
        end
      end
      StWaitEnd: begin
        if (!data_valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      hdr_cnt_q <= 3'd0;
      hdr_q     <= 32'd0;
      rem_q     <= 16'd0;
      ov_q      <= 1'b0;
      data_q    <= '0;
      be_q      <= '0;
      last_q    <= 1'b0;
      type_q    <= 3'd0;
      vc_q      <= 2'd0;
      wc_q      <= 16'd0;
      short_q   <= 1'b0;
      sdt_q     <= 6'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      hdr_q     <= hdr_d;
      rem_q     <= rem_d;
      ov_q      <= ov_d;
      data_q    <= data_d;
      be_q      <= be_d;
      last_q    <= last_d;
      type_q    <= type_d;
      vc_q      <= vc_d;
      wc_q      <= wc_d;
      short_q   <= short_d;
      sdt_q     <= sdt_d;
      err_q     <= err_d;
    end
  end

  assign output_valid_o = ov_q;
  assign data_o         = data_q;
  assign byte_en_o      = be_q;
  assign last_o         = last_q;
  assign packet_type_o  = type_q;
  assign vc_o           = vc_q;
  assign word_count_o   = wc_q;
  assign short_valid_o  = short_q;
  assign short_dt_o     = sdt_q;
  assign error_o        = err_q;

endmodule

// File: doc/mipi_csi_packet_decoder_nlane.md
MIPI_CSI_PACKET_DECODER_NLANE -- requirements
Module: mipi_csi_packet_decoder_nlane

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning byte lanes per beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hB8, meaning the HS sync byte.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port data_valid_i, input, 1, HS burst active; beat qualifier.
REQ-006 SHALL have port data_i, input, 8*LANES, lane-aligned bytes; lane 0 = bits [7:0] = earliest byte.
REQ-007 SHALL have port output_valid_o, output, 1, payload beat valid on data_o.
REQ-008 SHALL have port data_o, output, 8*LANES, payload bytes, same lane order as data_i.
REQ-009 SHALL have port byte_en_o, output, LANES, per-lane valid byte mask for data_o.
REQ-010 SHALL have port last_o, output, 1, final payload beat of a long packet.
REQ-011 SHALL have port packet_type_o, output, 3, 0=unsupported, 1=RAW8(0x2A), 2=RAW10(0x2B), 3=RAW12(0x2C), 4=YUV422-8(0x1E), 5=RGB888(0x24).
REQ-012 SHALL have port vc_o, output, 2, virtual channel of current packet.
REQ-013 SHALL have port word_count_o, output, 16, WC field of current packet.
REQ-014 SHALL have port short_valid_o, output, 1, one-cycle pulse per short packet.
REQ-015 SHALL have port short_dt_o, output, 6, data type of last short packet.
REQ-016 SHALL have port error_o, output, 1, one-cycle pulse on truncated packet.

Function
REQ-017 SHALL implement states IDLE, HEADER, PAYLOAD, WAIT_END.
REQ-018 IDLE: beat with data_valid_i=1 and every lane byte == SYNC_BYTE -> HEADER; any other beat stays in IDLE.
REQ-019 HEADER: SHALL collect 4 header bytes over 4/LANES valid beats, byte0=DI, byte1=WC[7:0], byte2=WC[15:8], byte3=ECC (ECC ignored).
REQ-020 On header completion SHALL register vc_o=DI[7:6], word_count_o=WC, packet_type_o from DI[5:0] per REQ-011.
REQ-021 DI[5:0] < 6'h10 (short): SHALL pulse short_valid_o, set short_dt_o=DI[5:0] the cycle after the last header beat, then -> WAIT_END.
REQ-022 Long packet, WC=0: -> WAIT_END, no payload beats.
REQ-023 Long packet, WC>0: -> PAYLOAD with 16-bit remaining-byte counter = WC.
REQ-024 PAYLOAD: each valid beat decrements counter by min(LANES, remaining); data_o registered, latency exactly 1 cycle.
REQ-025 output_valid_o SHALL assert per payload beat only if packet_type_o != 0; unsupported types consumed silently.
REQ-026 byte_en_o SHALL be all ones except on the last beat: low (remaining) bits set; 0 when output_valid_o=0.
REQ-027 last_o SHALL assert with output_valid_o on the beat that brings counter to 0; then -> WAIT_END.
REQ-028 WAIT_END: SHALL ignore beats (CRC footer, filler) until data_valid_i=0, then -> IDLE.
REQ-029 data_valid_i=0 in HEADER or PAYLOAD: SHALL pulse error_o next cycle, not assert last_o, -> IDLE.
REQ-030 In IDLE with data_valid_i=0: no state change, no output pulses.
REQ-031 vc_o, word_count_o, packet_type_o, short_dt_o SHALL hold until next header completes.

Reset
REQ-032 reset_i=1 SHALL asynchronously force state IDLE, counter 0, all outputs 0.
REQ-033 Reset mid-packet SHALL discard the packet with no error_o and no last_o; after release, a new sync is required.

Verification
REQ-034 LANES=4: sync B8B8B8B8, header AB09602B, 600 valid beats -> type 2, vc 0, WC 0x0960, 600 output_valid_o, last_o on beat 600 with byte_en 4'hF.
REQ-035 LANES=4: header 0x0000052A, 2 beats -> type 1, byte_en 4'hF then 4'h1 with last_o.
REQ-036 LANES=1: sync 0xB8, header bytes 00,01,00,xx -> short_valid_o pulse, short_dt_o 0, no output_valid_o.
REQ-037 LANES=4: RAW10 header, data_valid_i dropped after 10 payload beats -> 10 output_valid_o, error_o one pulse, no last_o, IDLE.
REQ-038 LANES=2: sync with one lane 0xB8 only -> stays IDLE; header DT 0x30 WC 4 -> no output_valid_o, type 0.
REQ-039 reset_i asserted mid-PAYLOAD -> all outputs 0 immediately; next full packet decodes correctly.
